sram_queue_ctrl: RTL and testbench

- Controller for one external 8-entry x 219-bit 1R1W synchronous-read array macro (registered read address, read data valid one cycle after the read enable).
- Presents a valid/ready FIFO on both sides and drives the macro's read and write ports.
- A single holding register hides the macro's read latency, so the dequeue side runs at one element per cycle with no bubbles.
- Sits between a producer stage and its consumer as the buffering wrapper around the array.

---
 rtl/sram_queue_ctrl_pkg.sv | 22 ++
 rtl/sram_queue_ctrl_if.sv | 32 +++
 rtl/sram_queue_out_stage.sv | 48 ++++
 rtl/sram_queue_ctrl.sv | 67 ++++++
 tb/tb_sram_queue_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/sram_queue_ctrl_pkg.sv
// Shared sizing, types and pointer helpers for the SRAM-backed queue controller.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
package sram_queue_ctrl_pkg;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 219;
    localparam int unsigned AW    = 3;

    typedef logic [AW:0]      ptr_t;
    typedef logic [AW:0]      count_t;
    typedef logic [AW-1:0]    idx_t;
    typedef logic [WIDTH-1:0] data_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

    function automatic idx_t ptr_idx(input ptr_t p);
        return p[AW-1:0];
    endfunction

endpackage

// File: rtl/sram_queue_ctrl_if.sv
// Enqueue/dequeue handshakes plus the array macro read and write ports.
// The master modport is the controller side; slave is the producer/consumer/macro side.
interface sram_queue_ctrl_if;
    import sram_queue_ctrl_pkg::*;

    logic   enq_valid;
    logic   enq_ready;
    data_t  enq_bits;
    logic   deq_valid;
    logic   deq_ready;
    data_t  deq_bits;
    count_t count;
    idx_t   R0_addr;
    logic   R0_en;
    data_t  R0_data;
    idx_t   W0_addr;
    logic   W0_en;
    data_t  W0_data;

    modport master (
        input  enq_valid, enq_bits, deq_ready, R0_data,
        output enq_ready, deq_valid, deq_bits, count,
        output R0_addr, R0_en, W0_addr, W0_en, W0_data
    );

    modport slave (
        output enq_valid, enq_bits, deq_ready, R0_data,
        input  enq_ready, deq_valid, deq_bits, count,
        input  R0_addr, R0_en, W0_addr, W0_en, W0_data
    );

endinterface

// File: rtl/sram_queue_out_stage.sv
// Presentation stage: hides the macro's one-cycle read latency behind a single
// holding register so the head element can be offered every cycle without bubbles.
module sram_queue_out_stage
    import sram_queue_ctrl_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  flush,
    input  logic  issue,
    input  data_t rd_data,
    input  logic  deq_ready,
    output logic  deq_valid,
    output data_t deq_bits,
    output logic  deq_fire,
    output logic  issue_ok
);

    logic  inflight;
    logic  out_valid;
    data_t out_reg;

    assign deq_valid = !flush && (out_valid || inflight);
    assign deq_bits  = out_valid ? out_reg : rd_data;
    assign deq_fire  = deq_valid && deq_ready;
    // A new read may only be launched when the presentation slot is free next cycle.
    assign issue_ok  = !deq_valid || deq_fire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight  <= 1'b0;
            out_valid <= 1'b0;
            out_reg   <= '0;
        end else if (flush) begin
            inflight  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            inflight <= issue;
            // Macro data is only valid this cycle, so park it if the consumer stalls.
            if (inflight && !deq_ready) begin
                out_valid <= 1'b1;
                out_reg   <= rd_data;
            end else if (deq_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sram_queue_ctrl.sv
// Valid/ready FIFO wrapper around an external 1R1W synchronous-read array macro.
// Slots are released on dequeue, never on read issue, so writes cannot hit a held slot.
module sram_queue_ctrl
    import sram_queue_ctrl_pkg::*;
(
    input logic               clock,
    input logic               reset,
    input logic               flush,
    sram_queue_ctrl_if.master bus
);

    ptr_t   wr_ptr_q;
    ptr_t   rd_ptr_q;
    count_t count_q;
    logic   enq_fire;
    logic   deq_fire;
    logic   unread;
    logic   issue;
    logic   issue_ok;

    assign bus.enq_ready = !flush && (count_q < count_t'(DEPTH));
    assign enq_fire      = bus.enq_valid && bus.enq_ready;
    // Full-width compare so the wrap bit separates full from empty.
    assign unread        = (rd_ptr_q != wr_ptr_q);
    assign issue         = !flush && unread && issue_ok;

    assign bus.W0_en   = enq_fire;
    assign bus.W0_addr = ptr_idx(wr_ptr_q);
    assign bus.W0_data = bus.enq_bits;
    assign bus.R0_en   = issue;
    assign bus.R0_addr = ptr_idx(rd_ptr_q);
    assign bus.count   = count_q;

    sram_queue_out_stage u_out_stage (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .issue     (issue),
        .rd_data   (bus.R0_data),
        .deq_ready (bus.deq_ready),
        .deq_valid (bus.deq_valid),
        .deq_bits  (bus.deq_bits),
        .deq_fire  (deq_fire),
        .issue_ok  (issue_ok)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (issue) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + count_t'(enq_fire) - count_t'(deq_fire);
        end
    end

endmodule

// File: tb/tb_sram_queue_ctrl.sv
// Bench for sram_queue_ctrl: directed scenarios plus random traffic, checked against
// a queue model where the head is presentable two cycles after its enqueue.
module tb_sram_queue_ctrl;
    import sram_queue_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    always #5 clock = ~clock;

    sram_queue_ctrl_if bus ();

    sram_queue_ctrl dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    // Behavioural 1R1W macro: registered read, data valid the cycle after R0_en.
    data_t mem [DEPTH];
    always @(posedge clock) begin
        if (bus.W0_en) mem[bus.W0_addr] <= bus.W0_data;
        if (bus.R0_en) bus.R0_data <= mem[bus.R0_addr];
    end

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    max_count = 0;
    data_t q_data[$];
    int    q_cyc[$];
    logic  obs_r0_en;
    idx_t  obs_r0_addr;

    task automatic chk(input string tag, input data_t got, input data_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic data_t rnd_word();
        logic [223:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[WIDTH-1:0];
    endfunction

    // One clock cycle: drive at negedge, check settled outputs, advance the model.
    task automatic step(input logic ev, input data_t eb, input logic dr, input logic fl);
        logic exp_ready;
        logic exp_valid;
        logic efire;
        logic dfire;
        @(negedge clock);
        bus.enq_valid = ev;
        bus.enq_bits  = eb;
        bus.deq_ready = dr;
        flush         = fl;
        #1;
        exp_ready = !fl && (q_data.size() < DEPTH);
        exp_valid = 1'b0;
        if (!fl && q_data.size() > 0) exp_valid = (q_cyc[0] <= cyc - 2);
        efire = ev && exp_ready;
        dfire = exp_valid && dr;
        chk("enq_ready", data_t'(bus.enq_ready), data_t'(exp_ready));
        chk("deq_valid", data_t'(bus.deq_valid), data_t'(exp_valid));
        chk("count", data_t'(bus.count), data_t'(q_data.size()));
        if (exp_valid) chk("deq_bits", bus.deq_bits, q_data[0]);
        chk("w0_en", data_t'(bus.W0_en), data_t'(efire));
        if (efire) chk("w0_data", bus.W0_data, eb);
        if (fl) chk("r0_en_in_flush", data_t'(bus.R0_en), data_t'(1'b0));
        obs_r0_en   = bus.R0_en;
        obs_r0_addr = bus.R0_addr;
        if (int'(bus.count) > max_count) max_count = int'(bus.count);
        if (fl) begin
            q_data.delete();
            q_cyc.delete();
        end else begin
            if (dfire) begin
                void'(q_data.pop_front());
                void'(q_cyc.pop_front());
            end
            if (efire) begin
                q_data.push_back(eb);
                q_cyc.push_back(cyc);
            end
        end
        cyc++;
    endtask

    initial begin
        logic dr_bias;
        reset         = 1'b1;
        flush         = 1'b0;
        bus.enq_valid = 1'b0;
        bus.enq_bits  = '0;
        bus.deq_ready = 1'b0;
        #12;
        chk("rst_enq_ready", data_t'(bus.enq_ready), data_t'(1'b1));
        chk("rst_deq_valid", data_t'(bus.deq_valid), data_t'(1'b0));
        chk("rst_count", data_t'(bus.count), data_t'(0));
        chk("rst_r0_en", data_t'(bus.R0_en), data_t'(1'b0));
        chk("rst_w0_en", data_t'(bus.W0_en), data_t'(1'b0));
        @(negedge clock);
        reset = 1'b0;

        // Single element: read at cycle 1 from slot 0, presented at cycle 2.
        step(1'b1, data_t'(16'h1234), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("single_r0_en", data_t'(obs_r0_en), data_t'(1'b1));
        chk("single_r0_addr", data_t'(obs_r0_addr), data_t'(0));
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Streaming past the pointer wrap.
        max_count = 0;
        for (int i = 0; i < 20; i++) step(1'b1, data_t'(i + 256), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("stream_max_count_le2", data_t'(max_count <= 2), data_t'(1'b1));

        // Fill and stall, then dequeue while full.
        for (int i = 0; i < 9; i++) step(1'b1, data_t'(i + 512), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, data_t'(16'h300), 1'b1, 1'b0);
        step(1'b1, data_t'(16'h301), 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Consumer stalls the cycle data arrives; no further reads until it fires.
        step(1'b1, data_t'(16'hA0A0), 1'b1, 1'b0);
        step(1'b1, data_t'(16'hB0B0), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            chk("stall_no_r0_en", data_t'(obs_r0_en), data_t'(1'b0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Flush with held contents; next enqueue lands in slot 0.
        for (int i = 0; i < 5; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, data_t'(16'h55), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("flush_r0_en", data_t'(obs_r0_en), data_t'(1'b1));
        chk("flush_r0_addr", data_t'(obs_r0_addr), data_t'(0));
        step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with a slowly changing consumer bias and rare flushes.
        dr_bias = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) dr_bias = ~dr_bias;
            step($urandom_range(0, 3) != 0, rnd_word(),
                 dr_bias ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 63) == 0);
        end

        // Asynchronous reset mid-cycle while an element is being presented.
        for (int i = 0; i < 3; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_deq_valid", data_t'(bus.deq_valid), data_t'(1'b0));
        chk("async_rst_count", data_t'(bus.count), data_t'(0));
        chk("async_rst_enq_ready", data_t'(bus.enq_ready), data_t'(1'b1));
        q_data.delete();
        q_cyc.delete();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, rnd_word(), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
